// File: rtl/span_fill_engine.sv
// Scanline fill: bounding-box origin, then per-row mask fetch and SRAM read-modify-write of one row word.
// Build option SPAN_FILL_SKIP_EMPTY_EN: rows whose clipped cover is empty skip the SRAM read/write.
module span_fill_engine #(
  parameter int ROW_PIXELS     = 64,
  parameter int NUM_ROWS       = 64,
  parameter int PIXEL_BITS     = 24,
  parameter int NUM_LAYERS     = 2,
  parameter int LAYER_STRIDE   = 65536,
  parameter int ROW_STRIDE     = 256,
  parameter int ADDR_SIZE_BITS = 18
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [47:0]                        coordinates,
  input  logic [PIXEL_BITS-1:0]              color_code,
  input  logic [$clog2(NUM_LAYERS)-1:0]      layer_num,
  input  logic                               fill_mode,
  output logic                               mask_req,
  output logic [$clog2(NUM_ROWS)-1:0]        mask_row,
  input  logic                               mask_valid,
  input  logic [ROW_PIXELS-1:0]              mask_data,
  output logic                               mem_read_en,
  output logic                               mem_write_en,
  output logic [ADDR_SIZE_BITS-1:0]          mem_addr,
  output logic [ROW_PIXELS*PIXEL_BITS-1:0]   mem_wdata,
  input  logic [ROW_PIXELS*PIXEL_BITS-1:0]   mem_rdata,
  input  logic                               mem_ack,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_ROWS+1)-1:0]      rows_written
);

  localparam int LW = $clog2(NUM_LAYERS);
  localparam int RW = $clog2(NUM_ROWS);
  localparam int CW = $clog2(NUM_ROWS + 1);
  localparam int DW = ROW_PIXELS * PIXEL_BITS;
  localparam logic [ADDR_SIZE_BITS-1:0] LP_LSTRIDE = ADDR_SIZE_BITS'(LAYER_STRIDE);
  localparam logic [ADDR_SIZE_BITS-1:0] LP_RSTRIDE = ADDR_SIZE_BITS'(ROW_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_BBOX, S_MASK, S_SCAN, S_RD, S_WR, S_NEXT, S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [47:0]               r_coords;
  logic [PIXEL_BITS-1:0]     r_color;
  logic [LW-1:0]             r_layer;
  logic                      r_mode;
  logic [7:0]                r_xmin;
  logic [7:0]                r_ymin;
  logic [CW-1:0]             r_row;
  logic [ROW_PIXELS-1:0]     r_mask;
  logic [ROW_PIXELS-1:0]     r_cover;
  logic                      r_mask_req;
  logic                      r_rd;
  logic                      r_wr;
  logic [ADDR_SIZE_BITS-1:0] r_addr;
  logic [DW-1:0]             r_wdata;
  logic [CW-1:0]             r_rows_written;

  logic [ROW_PIXELS-1:0]     w_pre;
  logic [ROW_PIXELS-1:0]     w_suf;
  logic [ROW_PIXELS-1:0]     w_cover;
  logic [DW-1:0]             w_merged;
  logic [ADDR_SIZE_BITS-1:0] w_addr;
  logic [CW-1:0]             w_row_inc;
  logic [9:0]                w_y_next;
  logic                      w_last_row;
  logic                      w_mask_take;
  logic                      w_rd_take;
  logic                      w_wr_take;

  function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // Handshakes only count once the registered strobe is actually visible.
  assign w_mask_take = r_mask_req & mask_valid;
  assign w_rd_take   = r_rd & mem_ack;
  assign w_wr_take   = r_wr & mem_ack;

  assign w_row_inc  = r_row + CW'(1);
  assign w_y_next   = 10'(r_ymin) + 10'(w_row_inc);
  assign w_last_row = (w_row_inc == CW'(NUM_ROWS)) || (w_y_next > 10'd255);

  assign w_addr = ADDR_SIZE_BITS'(r_layer) * LP_LSTRIDE
                + (ADDR_SIZE_BITS'(r_ymin) + ADDR_SIZE_BITS'(r_row)) * LP_RSTRIDE
                + ADDR_SIZE_BITS'(r_xmin);

  // SPAN cover is every bit with a set bit at or below it and at or above it.
  always_comb begin
    logic v_lo;
    logic v_hi;
    w_pre   = '0;
    w_suf   = '0;
    w_cover = '0;
    v_lo    = 1'b0;
    v_hi    = 1'b0;
    for (int j = 0; j < ROW_PIXELS; j++) begin
      v_lo     = v_lo | r_mask[j];
      w_pre[j] = v_lo;
    end
    for (int j = ROW_PIXELS - 1; j >= 0; j--) begin
      v_hi     = v_hi | r_mask[j];
      w_suf[j] = v_hi;
    end
    for (int j = 0; j < ROW_PIXELS; j++) begin
      w_cover[j] = (r_mode ? r_mask[j] : (w_pre[j] & w_suf[j]))
                 & ((10'(r_xmin) + 10'(j)) <= 10'd255);
    end
  end

  always_comb begin
    w_merged = '0;
    for (int j = 0; j < ROW_PIXELS; j++) begin
      w_merged[j*PIXEL_BITS +: PIXEL_BITS] = r_cover[j] ? r_color
                                                        : mem_rdata[j*PIXEL_BITS +: PIXEL_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_BBOX;
      S_BBOX: w_next = S_MASK;
      S_MASK: if (w_mask_take) w_next = S_SCAN;
      S_SCAN: begin
`ifdef SPAN_FILL_SKIP_EMPTY_EN
        w_next = (w_cover == '0) ? S_NEXT : S_RD;
`else
        w_next = S_RD;
`endif
      end
      S_RD:   if (w_rd_take) w_next = S_WR;
      S_WR:   if (w_wr_take) w_next = S_NEXT;
      S_NEXT: w_next = w_last_row ? S_DONE : S_MASK;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_coords       <= '0;
      r_color        <= '0;
      r_layer        <= '0;
      r_mode         <= 1'b0;
      r_xmin         <= '0;
      r_ymin         <= '0;
      r_row          <= '0;
      r_mask         <= '0;
      r_cover        <= '0;
      r_mask_req     <= 1'b0;
      r_rd           <= 1'b0;
      r_wr           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_rows_written <= '0;
    end else begin
      // Strobes rise one cycle into their state and drop on the accepting edge.
      r_mask_req <= (r_state == S_MASK) && (w_next == S_MASK);
      r_rd       <= (r_state == S_RD)   && (w_next == S_RD);
      r_wr       <= (r_state == S_WR)   && (w_next == S_WR);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_coords       <= coordinates;
            r_color        <= color_code;
            r_layer        <= layer_num;
            r_mode         <= fill_mode;
            r_row          <= '0;
            r_rows_written <= '0;
          end
        end
        S_BBOX: begin
          r_xmin <= min3(r_coords[7:0],  r_coords[23:16], r_coords[39:32]);
          r_ymin <= min3(r_coords[15:8], r_coords[31:24], r_coords[47:40]);
        end
        S_MASK: if (w_mask_take) r_mask <= mask_data;
        S_SCAN: begin
          r_cover <= w_cover;
          r_addr  <= w_addr;
        end
        S_RD:   if (w_rd_take) r_wdata <= w_merged;
        S_WR:   if (w_wr_take) r_rows_written <= r_rows_written + CW'(1);
        S_NEXT: r_row <= w_row_inc;
        default: ;
      endcase
    end
  end

  assign mask_req     = r_mask_req;
  assign mask_row     = r_row[RW-1:0];
  assign mem_read_en  = r_rd;
  assign mem_write_en = r_wr;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign rows_written = r_rows_written;

endmodule

// File: tb/tb_span_fill_engine.sv
// Bench for span_fill_engine: zero-wait mask/SRAM responders, expected SRAM writes queued per fill.
module tb_span_fill_engine;
  localparam int RP = 64;
  localparam int NR = 64;
  localparam int PB = 24;
  localparam int AW = 18;
  localparam int DW = RP * PB;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [47:0]   coordinates;
  logic [PB-1:0] color_code;
  logic [0:0]    layer_num;
  logic          fill_mode;
  logic          mask_req;
  logic [5:0]    mask_row;
  logic          mask_valid;
  logic [RP-1:0] mask_data;
  logic          mem_read_en;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          busy;
  logic          done;
  logic [6:0]    rows_written;

  logic [RP-1:0] tb_m0;
  logic [RP-1:0] tb_mn;
  logic          wr_hold;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_err = 0;

  span_fill_engine dut (
    .clk(clk), .rst(rst), .start(start), .coordinates(coordinates),
    .color_code(color_code), .layer_num(layer_num), .fill_mode(fill_mode),
    .mask_req(mask_req), .mask_row(mask_row), .mask_valid(mask_valid), .mask_data(mask_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .rows_written(rows_written)
  );

  always #5 clk = ~clk;

  function automatic logic [PB-1:0] pix(input logic [AW-1:0] a, input int j);
    return {a, 6'(j)};
  endfunction

  assign mask_valid = mask_req;
  assign mask_data  = (mask_row == 6'd0) ? tb_m0 : tb_mn;
  assign mem_ack    = mem_read_en | (mem_write_en & ~wr_hold);

  always_comb begin
    mem_rdata = '0;
    for (int j = 0; j < RP; j++) mem_rdata[j*PB +: PB] = pix(mem_addr, j);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int bad;
    bad = -1;
    n_cmp++;
    for (int j = 0; j < RP; j++)
      if (bad < 0 && act[j*PB +: PB] !== exp[j*PB +: PB]) bad = j;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL wr_data: pixel %0d got %0h expected %0h", bad, act[bad*PB +: PB], exp[bad*PB +: PB]);
    end
  endtask

  function automatic logic [RP-1:0] model_cover(input logic [RP-1:0] m, input logic mode, input logic [7:0] xmin);
    int first;
    int last;
    logic [RP-1:0] c;
    first = -1;
    last  = -1;
    c     = '0;
    for (int j = 0; j < RP; j++)
      if (m[j]) begin
        if (first < 0) first = j;
        last = j;
      end
    if (mode) c = m;
    else if (first >= 0)
      for (int j = first; j <= last; j++) c[j] = 1'b1;
    for (int j = 0; j < RP; j++)
      if (int'(xmin) + j > 255) c[j] = 1'b0;
    return c;
  endfunction

  function automatic logic [7:0] tmin(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    logic [7:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  // Scoreboard monitor: every accepted write and every done pulse pops an expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_read_en || mem_write_en)
        chk("rd_wr_exclusive", 64'(mem_read_en & mem_write_en), 64'd0);
      if (mem_write_en && mem_ack) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h, none expected", mem_addr);
        end else begin
          mon_e = wr_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
          chk_data(mem_wdata, mon_e.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: rows_written %0d", rows_written);
        end else begin
          chk("rows_written", 64'(rows_written), 64'(done_q.pop_front()));
          chk("writes_pending_at_done", 64'(wr_q.size()), 64'd0);
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_mask_req", 64'(mask_req), 64'd0);
    chk("rst_mask_row", 64'(mask_row), 64'd0);
    chk("rst_mem_read_en", 64'(mem_read_en), 64'd0);
    chk("rst_mem_write_en", 64'(mem_write_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata_nonzero", 64'(|mem_wdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rows_written", 64'(rows_written), 64'd0);
  endtask

  task automatic drive_start(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                             input logic [7:0] y1, input logic [7:0] x2, input logic [7:0] y2,
                             input logic [PB-1:0] col, input logic lay, input logic mode);
    @(negedge clk);
    coordinates = {y2, x2, y1, x1, y0, x0};
    color_code  = col;
    layer_num   = lay;
    fill_mode   = mode;
    start       = 1'b1;
  endtask

  task automatic run_fill(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                          input logic [7:0] y1, input logic [7:0] x2, input logic [7:0] y2,
                          input logic [PB-1:0] col, input logic lay, input logic mode,
                          input logic [RP-1:0] m0, input logic [RP-1:0] mn, input logic poke);
    logic [7:0]    xmin;
    logic [7:0]    ymin;
    logic [RP-1:0] cov;
    logic [AW-1:0] a;
    wr_t           e;
    int            nrows;
    int            nwr;
    int            skipped;
    int            cyc;
    bit            got;
    xmin    = tmin(x0, x1, x2);
    ymin    = tmin(y0, y1, y2);
    nrows   = 256 - int'(ymin);
    if (nrows > NR) nrows = NR;
    nwr     = 0;
    skipped = 0;
    for (int r = 0; r < nrows; r++) begin
      cov = model_cover((r == 0) ? m0 : mn, mode, xmin);
`ifdef SPAN_FILL_SKIP_EMPTY_EN
      if (cov == '0) begin
        skipped++;
        continue;
      end
`endif
      a = AW'(int'(lay) * 65536 + (int'(ymin) + r) * 256 + int'(xmin));
      e.addr = a;
      e.data = '0;
      for (int j = 0; j < RP; j++) e.data[j*PB +: PB] = cov[j] ? col : pix(a, j);
      wr_q.push_back(e);
      nwr++;
    end
    done_q.push_back(nwr);
    tb_m0 = m0;
    tb_mn = mn;
    drive_start(x0, y0, x1, y1, x2, y2, col, lay, mode);
    cyc = 0;
    got = 0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start       = 1'b0;
        coordinates = ~coordinates;
        color_code  = ~col;
        layer_num   = ~lay;
        fill_mode   = ~mode;
        chk("busy_after_start", 64'(busy), 64'd1);
      end
      if (poke && cyc == 20) start = 1'b1;
      if (poke && cyc == 21) start = 1'b0;
      if (done) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL fill_timeout: no done after %0d cycles, required done", cyc);
    end else begin
      // Edges from the start edge until done is visible: 2 + 8 per row, skipped rows save 4.
      chk("fill_latency", 64'(cyc), 64'(2 + 8 * nrows - 4 * skipped));
    end
    @(negedge clk);
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_single_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    bit seen;
    rst         = 1'b1;
    start       = 1'b0;
    coordinates = '0;
    color_code  = '0;
    layer_num   = '0;
    fill_mode   = 1'b0;
    tb_m0       = '0;
    tb_mn       = '0;
    wr_hold     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // xmin 10, ymin 5: first write at 0x0050A, pixels 4..7 coloured; stray start mid-fill.
    run_fill(8'd10, 8'd20, 8'd30, 8'd5, 8'd12, 8'd40, 24'hABCDEF, 1'b0, 1'b0,
             64'h0000_0000_0000_00F0, 64'h0000_0000_0001_0100, 1'b1);
    // MASK mode on layer 1: only set bits, addresses offset by 65536.
    run_fill(8'd100, 8'd200, 8'd120, 8'd210, 8'd110, 8'd220, 24'h123456, 1'b1, 1'b1,
             64'h0000_0000_0000_8001, 64'h8001_0000_0000_8001, 1'b0);
    // Bottom clip: ymin 250 gives exactly 6 rows.
    run_fill(8'd0, 8'd250, 8'd5, 8'd252, 8'd3, 8'd255, 24'h00FF00, 1'b0, 1'b0,
             64'h0000_0000_0000_FF00, 64'h0000_0000_0000_FF00, 1'b0);
    // Right clip: xmin 240 keeps pixels 0..15 only.
    run_fill(8'd240, 8'd30, 8'd250, 8'd31, 8'd245, 8'd32, 24'h0F0F0F, 1'b0, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    // Empty first row, then a narrow MASK pattern.
    run_fill(8'd3, 8'd3, 8'd4, 8'd4, 8'd5, 8'd5, 24'h777777, 1'b1, 1'b1,
             64'h0, 64'h0000_0000_0000_003C, 1'b0);

    // Reset while a write is stalled; no access may follow.
    tb_m0   = 64'hFFFF_FFFF_FFFF_FFFF;
    tb_mn   = 64'hFFFF_FFFF_FFFF_FFFF;
    wr_hold = 1'b1;
    drive_start(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 24'h55AA55, 1'b0, 1'b0);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (mem_write_en) seen = 1;
    end
    chk("write_strobe_before_reset", 64'(mem_write_en), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst     = 1'b0;
    wr_hold = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_reset_read", 64'(mem_read_en), 64'd0);

    run_fill(8'd0, 8'd250, 8'd5, 8'd252, 8'd3, 8'd255, 24'hC0FFEE, 1'b1, 1'b1,
             64'h8000_0000_0000_0001, 64'h0000_0000_0000_0005, 1'b0);

    chk("writes_left_at_end", 64'(wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/span_fill_engine.md
# span_fill_engine

Parametrised scanline fill engine for the 2D GPU raster path. On `start` it computes the triangle bounding-box origin from three packed vertices. It then walks up to `NUM_ROWS` rows: for each row it fetches a coverage mask from the line-buffer interface, performs a read-modify-write of one SRAM row word in the selected layer buffer, and writes `color_code` into covered pixels. It sits between the decode/rasterise stage and the SRAM controller.

## Interface
Parameters:
- `ROW_PIXELS`, 64: pixels per SRAM row word and per mask row.
- `NUM_ROWS`, 64: maximum rows per fill.
- `PIXEL_BITS`, 24: bits per pixel.
- `NUM_LAYERS`, 2: number of layer buffers.
- `LAYER_STRIDE`, 65536: address offset between layer buffers.
- `ROW_STRIDE`, 256: address offset between screen rows.
- `ADDR_SIZE_BITS`, 18: address width.

Ports:
- Reset and clocking: one clock `clk`. Reset `rst` is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin fill; sampled only in IDLE.
- `coordinates`  in  48  vertex fields: {y2,x2,y1,x1,y0,x0}, 8 bits each, x0 in [7:0].
- `color_code`  in  PIXEL_BITS  fill colour; latched at start.
- `layer_num`  in  $clog2(NUM_LAYERS)  target layer; latched at start.
- `fill_mode`  in  1  0 = SPAN (first..last set bit inclusive), 1 = MASK (set bits only); latched at start.
- `mask_req`  out  1  mask row request.
- `mask_row`  out  $clog2(NUM_ROWS)  requested row index.
- `mask_valid`  in  1  mask data valid.
- `mask_data`  in  ROW_PIXELS  coverage bits; bit j = pixel xmin+j.
- `mem_read_en`, `mem_write_en`  out  1  SRAM strobes.
- `mem_addr`  out  ADDR_SIZE_BITS  SRAM address.
- `mem_wdata`  out  ROW_PIXELS*PIXEL_BITS  write data; pixel j occupies [j*PIXEL_BITS +: PIXEL_BITS].
- `mem_rdata`  in  ROW_PIXELS*PIXEL_BITS  read data.
- `mem_ack`  in  1  access complete.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rows_written`  out  $clog2(NUM_ROWS+1)  SRAM writes issued in the current or last fill.

## Operation
- IDLE: if `start`, latch inputs, clear `rows_written` and row counter, go to BBOX.
- BBOX (1 cycle): xmin = min(x0,x1,x2), ymin = min(y0,y1,y2), unsigned 8-bit. Then MASK.
- MASK: hold `mask_req` high with `mask_row` = row until `mask_valid`. Capture `mask_data`, then SCAN.
- SCAN (1 cycle): find first and last set bits.
  - Cover set, SPAN mode: bits first..last inclusive.
  - Cover set, MASK mode: the mask bits as given.
  - Clip: any pixel with xmin+j > 255 is removed from the cover.
  - Then RD.
- RD: assert `mem_read_en`, addr = layer_num*LAYER_STRIDE + (ymin+row)*ROW_STRIDE + xmin, truncated to ADDR_SIZE_BITS. On `mem_ack`, capture `mem_rdata` and go to WR.
- WR: `mem_wdata` = captured data with covered pixels replaced by `color_code`. Assert `mem_write_en` at the same address until `mem_ack`, then increment `rows_written` and go to NEXT.
- NEXT: row++. If row == NUM_ROWS, or ymin+row > 255 (9-bit compare), go to DONE; else MASK.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` while busy is ignored. `mem_ack` outside RD/WR and `mask_valid` outside MASK are ignored.
- `mem_read_en` and `mem_write_en` are never high together.

## Timing
- Reset values: `mask_req`, `mask_row`, `mem_read_en`, `mem_write_en`, `mem_addr`, `mem_wdata`, `busy`, `done`, `rows_written` all 0. State is IDLE.
- `rst` mid-operation: the next edge returns to IDLE and drops strobes; no further access is issued.
- Strobes are registered. They assert the cycle after state entry and deassert the cycle after the `mem_ack` edge.
- Per-row latency with zero-wait responders (valid/ack on the first strobed cycle): MASK 2 + SCAN 1 + RD 2 + WR 2 + NEXT 1 = 8 cycles.
- Total latency = 2 (IDLE→BBOX→MASK) + 8 × rows + 1 (DONE).
- `done` rises in the cycle after the final NEXT.

## Configuration
- `SPAN_FILL_SKIP_EMPTY_EN` defined: a row with an all-zero (post-clip) cover skips RD/WR and goes SCAN→NEXT. `rows_written` does not count it.
- Undefined: every row performs RD and WR. An empty row writes back the read data unchanged.

## Test plan
- SPAN fill, layer 0: vertices (10,20),(30,5),(12,40) → xmin 10, ymin 5. Row 0 mask 0x00F0 → addr 0x0050A; pixels 4..7 = colour; other pixels equal `mem_rdata`.
- MASK mode, layer 1: mask 0x8001 → only pixels 0 and 15 written; first addr = 65536 + ymin*256 + xmin.
- Bottom clip: ymin = 250, NUM_ROWS = 64 → exactly 6 writes; `done` pulses; `rows_written` = 6.
- Right clip: xmin = 240, mask all-ones → pixels 0..15 coloured, 16..63 unchanged.
- Empty row: mask 0 → with macro, no strobes for that row; without macro, write data equals read data.
- Reset mid-WR: assert `rst` while `mem_write_en` is high → next cycle all outputs 0, `busy` 0; a `start` after reset completes normally.
